// File: rtl/antidiff_pkg.sv
// antidiff_pkg: shared FSM state type, signed bound helpers and order clamp for the anti-difference engine
package antidiff_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    // Largest representable value of a w-bit two's complement number
    function automatic longint smax(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Smallest representable value of a w-bit two's complement number
    function automatic longint smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Requested pass count limited to what the engine supports
    function automatic int clamp_ord(input int order_sel, input int max_order);
        return (order_sel > max_order) ? max_order : order_sel;
    endfunction

endpackage

// File: rtl/antidiff_sat_add.sv
// antidiff_sat_add: combinational WIDTH-bit signed add, saturating or wrapping, with overflow flag
//   a, b   : signed operands
//   sat_en : 1 clamps to the signed range on overflow, 0 keeps the low WIDTH bits
//   sum    : result
//   ovf    : true sum fell outside the WIDTH-bit signed range
module antidiff_sat_add
    import antidiff_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sat_en,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovf
);
    localparam logic signed [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
    localparam logic signed [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));

    logic signed [WIDTH:0] s;

    assign s   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // The top two bits of the extended sum disagree exactly when the result left the range
    assign ovf = s[WIDTH] ^ s[WIDTH-1];
    assign sum = (ovf && sat_en) ? (s[WIDTH] ? SMIN : SMAX) : s[WIDTH-1:0];
endmodule

// File: rtl/antidiff_engine_param.sv
// antidiff_engine_param: applies the running-sum operator ord times to a captured block, one element per clock
//   en/order_sel/sat_en/in : start pulse and block parameters, sampled together in IDLE
//   out/overflow           : result and sticky overflow of the last completed block, held between completions
//   busy                   : block in progress
//   done                   : one-cycle completion pulse
module antidiff_engine_param
    import antidiff_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LEN       = 19,
    parameter int MAX_ORDER = 4,
    parameter int ORD_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [ORD_W-1:0]        order_sel,
    input  logic                    sat_en,
    input  logic signed [WIDTH-1:0] in  [LEN],
    output logic signed [WIDTH-1:0] out [LEN],
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int KW = $clog2(LEN);

    state_t                  state;
    logic signed [WIDTH-1:0] work [LEN];
    logic [KW-1:0]           k;
    logic [KW-1:0]           km1;
    logic [ORD_W-1:0]        p;
    logic [ORD_W-1:0]        ord;
    logic [ORD_W-1:0]        ord_in;
    logic                    sat;
    logic                    sticky;
    logic signed [WIDTH-1:0] sum;
    logic                    ovf;

    assign ord_in = ORD_W'(clamp_ord(int'(order_sel), MAX_ORDER));
    assign km1    = (k == '0) ? '0 : k - 1'b1;

    // Single shared adder; work[k-1] already holds its running sum for this pass
    antidiff_sat_add #(.WIDTH(WIDTH)) u_add (
        .a      (work[k]),
        .b      (work[km1]),
        .sat_en (sat),
        .sum    (sum),
        .ovf    (ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            sticky   <= 1'b0;
            sat      <= 1'b0;
            k        <= '0;
            p        <= '0;
            ord      <= '0;
            for (int i = 0; i < LEN; i++) begin
                out[i]  <= '0;
                work[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    work   <= in;
                    ord    <= ord_in;
                    sat    <= sat_en;
                    sticky <= 1'b0;
                    busy   <= 1'b1;
                    k      <= '0;
                    p      <= '0;
                    state  <= (ord_in == '0) ? FINISH : RUN;
                end
                RUN: begin
                    if (k != '0) begin
                        work[k] <= sum;
                        sticky  <= sticky | ovf;
                    end
                    if (k == KW'(LEN - 1)) begin
                        k <= '0;
                        p <= p + 1'b1;
                        if (p == ord - 1'b1) state <= FINISH;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FINISH: begin
                    out      <= work;
                    overflow <= sticky;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_antidiff_engine_param.sv
// tb_antidiff_engine_param: directed self-checking bench for antidiff_engine_param
module tb_antidiff_engine_param;
    localparam int WIDTH = 16;
    localparam int LEN   = 19;
    localparam int ORD_W = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    en = 1'b0;
    logic [ORD_W-1:0]        order_sel = '0;
    logic                    sat_en = 1'b0;
    logic signed [WIDTH-1:0] in  [LEN];
    logic signed [WIDTH-1:0] out [LEN];
    logic                    busy, done, overflow;

    int pass_cnt = 0;
    int total = 0;

    logic signed [WIDTH-1:0] din [LEN] = '{0,0,-8,8,-8,8,-8,0,16,-24,16,0,-16,0,0,0,0,0,0};
    logic signed [WIDTH-1:0] e1  [LEN] = '{0,0,-8,0,-8,0,-8,-8,8,-16,0,0,-16,-16,-16,-16,-16,-16,-16};
    logic signed [WIDTH-1:0] e2  [LEN] = '{0,0,-8,-8,-16,-16,-24,-32,-24,-40,-40,-40,-56,-72,-88,-104,-120,-136,-152};
    logic signed [WIDTH-1:0] e4  [LEN] = '{0,0,-8,-24,-56,-104,-176,-280,-408,-576,-784,-1032,-1336,-1712,-2176,-2744,-3432,-4256,-5232};
    logic signed [WIDTH-1:0] big [LEN];
    logic signed [WIDTH-1:0] alt [LEN];

    antidiff_engine_param #(.WIDTH(WIDTH), .LEN(LEN), .MAX_ORDER(4), .ORD_W(ORD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .order_sel (order_sel),
        .sat_en    (sat_en),
        .in        (in),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else pass_cnt++;
    endtask

    // Drives a one-cycle start pulse; returns #1 after the sampling edge E
    task automatic start(input int ord, input logic sat);
        @(negedge clk);
        in = din;
        order_sel = ORD_W'(ord);
        sat_en = sat;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Counts edges after E until done; also checks done is a single-cycle pulse
    task automatic wait_done(input int exp_lat, input string tag);
        int n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        chk(tag, n, exp_lat);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 0);
    endtask

    task automatic chk_arr(input string tag, input logic signed [WIDTH-1:0] exp [LEN]);
        for (int i = 0; i < LEN; i++) chk($sformatf("%s[%0d]", tag, i), out[i], exp[i]);
    endtask

    initial begin
        int ndone, first;
        for (int i = 0; i < LEN; i++) begin
            in[i]  = '0;
            big[i] = 16'sd20000;
            alt[i] = 16'sd1000;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out0", out[0], 0);
        chk("rst_out18", out[18], 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b0;

        start(1, 1'b1);
        chk("ord1_busy", busy, 1);
        wait_done(20, "ord1_lat");
        chk_arr("ord1", e1);
        chk("ord1_ovf", overflow, 0);
        chk("ord1_idle_busy", busy, 0);

        start(2, 1'b1);
        chk("ord2_hold", out[2], -8);
        wait_done(39, "ord2_lat");
        chk_arr("ord2", e2);

        start(0, 1'b1);
        wait_done(1, "ord0_lat");
        chk_arr("ord0", din);

        start(7, 1'b1);
        wait_done(77, "ord7_lat");
        chk_arr("ord7", e4);
        chk("ord7_ovf", overflow, 0);

        din = big;
        start(1, 1'b1);
        wait_done(20, "sat_lat");
        chk("sat_out0", out[0], 20000);
        for (int i = 1; i < LEN; i++) chk($sformatf("sat[%0d]", i), out[i], 32767);
        chk("sat_ovf", overflow, 1);

        start(1, 1'b0);
        wait_done(20, "wrap_lat");
        chk("wrap_out0", out[0], 20000);
        chk("wrap_out1", out[1], -25536);
        chk("wrap_out2", out[2], -5536);
        chk("wrap_ovf", overflow, 1);

        // en pulse mid-block with different inputs must be ignored
        din = alt;
        start(1, 1'b1);
        ndone = 0;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first == 0) first = n;
            end
            if (n == 4) begin
                in = din;
                order_sel = '0;
                en = 1'b1;
            end
            if (n == 5) en = 1'b0;
        end
        chk("busy_en_ndone", ndone, 1);
        chk("busy_en_lat", first, 20);
        chk("busy_en_out18", out[18], 19000);
        chk("busy_en_ovf", overflow, 0);

        // reset mid-block abandons it
        din = big;
        start(2, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("mrst_out18", out[18], 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mrst_nodone", ndone, 0);
        chk("mrst_idle_busy", busy, 0);

        din = din;
        for (int i = 0; i < LEN; i++) din[i] = (i == 3) ? 16'sd5 : 16'sd0;
        start(2, 1'b1);
        wait_done(39, "fresh_lat");
        chk("fresh_out2", out[2], 0);
        chk("fresh_out3", out[3], 5);
        chk("fresh_out4", out[4], 10);
        chk("fresh_out18", out[18], 80);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
